// File: rtl/e203_itcm_ram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : e203_itcm_ram_ctrl_pkg
// Description : Shared constants and state encoding for the ITCM SRAM
//               controller and its init-clear sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package e203_itcm_ram_ctrl_pkg;

    // Default geometry: 32768 x 64-bit words, byte-maskable
    localparam int ITCM_DP_DEFAULT = 32768;
    localparam int ITCM_AW_DEFAULT = 15;
    localparam int ITCM_DW_DEFAULT = 64;
    localparam int ITCM_MW_DEFAULT = 8;

    // Controller states; INIT exists only when init-clear is compiled in
    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } itcm_state_e;

endpackage
`default_nettype wire

// File: rtl/e203_itcm_init_seq.sv
`default_nettype none
// ============================================================================
// Module      : e203_itcm_init_seq
// Description : Init-clear sweep counter. Walks word addresses 0..DP-1 one
//               per cycle after reset and then parks with its done flag set.
// Revision    : 1.0 - initial release
// ============================================================================
module e203_itcm_init_seq
    import e203_itcm_ram_ctrl_pkg::*;
#(
    parameter int DP = ITCM_DP_DEFAULT,
    parameter int AW = ITCM_AW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [AW-1:0] sweep_addr,
    output logic          sweep_last,
    output logic          sweep_active
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DP - 1);

    logic [AW-1:0] cnt_q;
    logic [AW-1:0] cnt_d;
    logic          done_q;
    logic          done_d;

    assign sweep_addr   = cnt_q;
    assign sweep_last   = ~done_q & (cnt_q == LAST_ADDR);
    assign sweep_active = ~done_q;

    // Advance the sweep address until the last word, then latch done
    always_comb begin
        cnt_d  = cnt_q;
        done_d = done_q;
        if (!done_q) begin
            if (cnt_q == LAST_ADDR) begin
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + AW'(1);
            end
        end
    end

    // Sweep registers; reset restarts the sweep from address 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/e203_itcm_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : e203_itcm_ram_ctrl
// Description : ICB-to-single-port-SRAM bridge for the ITCM. One command per
//               cycle, response one cycle later, out-of-range addresses answer
//               with an error. Optional macro E203_ITCM_INIT_CLR_EN adds an
//               INIT state that zero-fills the whole array after reset.
// Revision    : 1.0 - initial release
// ============================================================================
module e203_itcm_ram_ctrl
    import e203_itcm_ram_ctrl_pkg::*;
#(
    parameter int DP = ITCM_DP_DEFAULT,
    parameter int AW = ITCM_AW_DEFAULT,
    parameter int DW = ITCM_DW_DEFAULT,
    parameter int MW = ITCM_MW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          icb_cmd_valid,
    output logic          icb_cmd_ready,
    input  logic          icb_cmd_read,
    input  logic [AW-1:0] icb_cmd_addr,
    input  logic [DW-1:0] icb_cmd_wdata,
    input  logic [MW-1:0] icb_cmd_wmask,
    output logic          icb_rsp_valid,
    input  logic          icb_rsp_ready,
    output logic [DW-1:0] icb_rsp_rdata,
    output logic          icb_rsp_err,
    output logic          ram_cs,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [MW-1:0] ram_wem,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout,
    output logic          ram_ls,
    output logic          init_done
);

    // DP widened by one bit so DP == 2**AW still compares correctly
    localparam logic [AW:0] DP_LIM = (AW+1)'(DP);

    itcm_state_e state_q;
    logic        run;
    logic        cmd_hsk;
    logic        in_range;

    logic        rsp_valid_q;
    logic        rsp_valid_d;
    logic        rsp_err_q;
    logic        rsp_err_d;
    logic        rsp_read_q;
    logic        rsp_read_d;

`ifdef E203_ITCM_INIT_CLR_EN
    itcm_state_e   state_d;
    logic [AW-1:0] sweep_addr;
    logic          sweep_last;
    logic          sweep_active;

    e203_itcm_init_seq #(
        .DP (DP),
        .AW (AW)
    ) u_init_seq (
        .clk          (clk),
        .rst_n        (rst_n),
        .sweep_addr   (sweep_addr),
        .sweep_last   (sweep_last),
        .sweep_active (sweep_active)
    );

    // Leave INIT in the cycle after the last word has been cleared
    always_comb begin
        state_d = state_q;
        if ((state_q == ST_INIT) && sweep_last) begin
            state_d = ST_RUN;
        end
    end

    // State register; every reset re-runs the clear sweep
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end
`else
    assign state_q = ST_RUN;
`endif

    // Gate with rst_n so nothing is accepted while reset is held
    assign run           = rst_n & (state_q == ST_RUN);
    assign icb_cmd_ready = run & (~rsp_valid_q | icb_rsp_ready);
    assign cmd_hsk       = icb_cmd_valid & icb_cmd_ready;
    assign in_range      = {1'b0, icb_cmd_addr} < DP_LIM;
    assign ram_ls        = run & ~cmd_hsk;
    assign init_done     = run;

    // SRAM strobe: init sweep while clearing, else pass the command through
    always_comb begin
        ram_cs   = cmd_hsk & in_range;
        ram_we   = ~icb_cmd_read;
        ram_addr = icb_cmd_addr;
        ram_wem  = icb_cmd_wmask;
        ram_din  = icb_cmd_wdata;
`ifdef E203_ITCM_INIT_CLR_EN
        if (rst_n && (state_q == ST_INIT)) begin
            ram_cs   = sweep_active;
            ram_we   = 1'b1;
            ram_addr = sweep_addr;
            ram_wem  = '1;
            ram_din  = '0;
        end
`endif
    end

    // Response slot: loaded on accept, cleared when drained with nothing new
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_read_d  = rsp_read_q;
        if (cmd_hsk) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = ~in_range;
            rsp_read_d  = icb_cmd_read & in_range;
        end else if (icb_rsp_ready) begin
            rsp_valid_d = 1'b0;
            rsp_err_d   = 1'b0;
            rsp_read_d  = 1'b0;
        end
    end

    // Response registers; reset drops any pending response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_read_q  <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_read_q  <= rsp_read_d;
        end
    end

    // SRAM holds its output until the next read, so it can feed rdata directly
    assign icb_rsp_valid = rsp_valid_q;
    assign icb_rsp_err   = rsp_err_q;
    assign icb_rsp_rdata = (rsp_valid_q & rsp_read_q) ? ram_dout : '0;

endmodule
`default_nettype wire

// File: tb/tb_e203_itcm_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_e203_itcm_ram_ctrl
// Description : Directed self-checking bench for e203_itcm_ram_ctrl with a
//               behavioural byte-maskable SRAM. Build with
//               E203_ITCM_INIT_CLR_EN to exercise the init-clear sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_e203_itcm_ram_ctrl;

`ifdef E203_ITCM_INIT_CLR_EN
    localparam int TB_DP = 16;
`else
    localparam int TB_DP = 32768;
`endif
    localparam int TB_AW = 16;

    logic              clk;
    logic              rst_n;
    logic              icb_cmd_valid;
    logic              icb_cmd_ready;
    logic              icb_cmd_read;
    logic [TB_AW-1:0]  icb_cmd_addr;
    logic [63:0]       icb_cmd_wdata;
    logic [7:0]        icb_cmd_wmask;
    logic              icb_rsp_valid;
    logic              icb_rsp_ready;
    logic [63:0]       icb_rsp_rdata;
    logic              icb_rsp_err;
    logic              ram_cs;
    logic              ram_we;
    logic [TB_AW-1:0]  ram_addr;
    logic [7:0]        ram_wem;
    logic [63:0]       ram_din;
    logic [63:0]       ram_dout = '0;
    logic              ram_ls;
    logic              init_done;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [63:0] mem [0:65535];

    e203_itcm_ram_ctrl #(
        .DP (TB_DP),
        .AW (TB_AW),
        .DW (64),
        .MW (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .icb_cmd_valid (icb_cmd_valid),
        .icb_cmd_ready (icb_cmd_ready),
        .icb_cmd_read  (icb_cmd_read),
        .icb_cmd_addr  (icb_cmd_addr),
        .icb_cmd_wdata (icb_cmd_wdata),
        .icb_cmd_wmask (icb_cmd_wmask),
        .icb_rsp_valid (icb_rsp_valid),
        .icb_rsp_ready (icb_rsp_ready),
        .icb_rsp_rdata (icb_rsp_rdata),
        .icb_rsp_err   (icb_rsp_err),
        .ram_cs        (ram_cs),
        .ram_we        (ram_we),
        .ram_addr      (ram_addr),
        .ram_wem       (ram_wem),
        .ram_din       (ram_din),
        .ram_dout      (ram_dout),
        .ram_ls        (ram_ls),
        .init_done     (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM: byte-masked write, registered read held until next read
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) begin
                for (int b = 0; b < 8; b++) begin
                    if (ram_wem[b]) mem[ram_addr][b*8 +: 8] <= ram_din[b*8 +: 8];
                end
            end else begin
                ram_dout <= mem[ram_addr];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        icb_cmd_valid = 1'b0;
        icb_cmd_read  = 1'b1;
        icb_cmd_addr  = '0;
        icb_cmd_wdata = '0;
        icb_cmd_wmask = '0;
    endtask

    task automatic drive_cmd(input logic rd, input logic [TB_AW-1:0] a,
                             input logic [63:0] wd, input logic [7:0] wm);
        icb_cmd_valid = 1'b1;
        icb_cmd_read  = rd;
        icb_cmd_addr  = a;
        icb_cmd_wdata = wd;
        icb_cmd_wmask = wm;
    endtask

    // Wait for the init sweep (if any) to complete, bounded
    task automatic wait_ready();
        int k;
        k = 0;
        while (!init_done && k < 200) begin
            tick();
            k++;
        end
        if (!init_done) begin
            vec_cnt++; err_cnt++;
            $display("FAIL wait_init_done: timed out after %0d cycles", k);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        icb_rsp_ready = 1'b1;
        drive_cmd(1'b1, 16'd5, 64'h0, 8'h0);
        tick(); tick();
        vec_cnt++; if (ram_cs !== 1'b0) begin err_cnt++; $display("FAIL rst_ram_cs: got %b want 0", ram_cs); end
        vec_cnt++; if (icb_cmd_ready !== 1'b0) begin err_cnt++; $display("FAIL rst_cmd_ready: got %b want 0", icb_cmd_ready); end
        vec_cnt++; if (init_done !== 1'b0) begin err_cnt++; $display("FAIL rst_init_done: got %b want 0", init_done); end
        vec_cnt++; if (icb_rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_rsp_valid: got %b want 0", icb_rsp_valid); end
        vec_cnt++; if (icb_rsp_err !== 1'b0) begin err_cnt++; $display("FAIL rst_rsp_err: got %b want 0", icb_rsp_err); end
        set_idle();
        rst_n = 1'b1;
        #1;
        wait_ready();
        vec_cnt++; if (init_done !== 1'b1) begin err_cnt++; $display("FAIL run_init_done: got %b want 1", init_done); end
        vec_cnt++; if (icb_cmd_ready !== 1'b1) begin err_cnt++; $display("FAIL run_cmd_ready: got %b want 1", icb_cmd_ready); end
        vec_cnt++; if (ram_ls !== 1'b1) begin err_cnt++; $display("FAIL run_idle_ls: got %b want 1", ram_ls); end
        vec_cnt++; if (icb_rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL run_rsp_valid: got %b want 0", icb_rsp_valid); end
    endtask

    task automatic test_write_read();
        drive_cmd(1'b0, 16'd5, 64'h1122334455667788, 8'hFF);
        #1;
        vec_cnt++; if (ram_cs !== 1'b1) begin err_cnt++; $display("FAIL wr_ram_cs: got %b want 1", ram_cs); end
        vec_cnt++; if (ram_we !== 1'b1) begin err_cnt++; $display("FAIL wr_ram_we: got %b want 1", ram_we); end
        vec_cnt++; if (ram_addr !== 16'd5) begin err_cnt++; $display("FAIL wr_ram_addr: got %0d want 5", ram_addr); end
        vec_cnt++; if (ram_din !== 64'h1122334455667788) begin err_cnt++; $display("FAIL wr_ram_din: got %h want 1122334455667788", ram_din); end
        vec_cnt++; if (ram_wem !== 8'hFF) begin err_cnt++; $display("FAIL wr_ram_wem: got %h want ff", ram_wem); end
        vec_cnt++; if (ram_ls !== 1'b0) begin err_cnt++; $display("FAIL wr_ram_ls: got %b want 0", ram_ls); end
        tick();
        drive_cmd(1'b1, 16'd5, 64'h0, 8'h0);
        #1;
        vec_cnt++; if (icb_rsp_valid !== 1'b1) begin err_cnt++; $display("FAIL wr_rsp_valid: got %b want 1", icb_rsp_valid); end
        vec_cnt++; if (icb_rsp_rdata !== 64'h0) begin err_cnt++; $display("FAIL wr_rsp_rdata: got %h want 0", icb_rsp_rdata); end
        vec_cnt++; if (icb_rsp_err !== 1'b0) begin err_cnt++; $display("FAIL wr_rsp_err: got %b want 0", icb_rsp_err); end
        vec_cnt++; if (ram_cs !== 1'b1 || ram_we !== 1'b0) begin err_cnt++; $display("FAIL rd_strobe: got cs=%b we=%b want cs=1 we=0", ram_cs, ram_we); end
        tick();
        set_idle();
        #1;
        vec_cnt++; if (icb_rsp_valid !== 1'b1) begin err_cnt++; $display("FAIL rd_rsp_valid: got %b want 1", icb_rsp_valid); end
        vec_cnt++; if (icb_rsp_rdata !== 64'h1122334455667788) begin err_cnt++; $display("FAIL rd_rsp_rdata: got %h want 1122334455667788", icb_rsp_rdata); end
        vec_cnt++; if (icb_rsp_err !== 1'b0) begin err_cnt++; $display("FAIL rd_rsp_err: got %b want 0", icb_rsp_err); end
        tick();
        vec_cnt++; if (icb_rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL rd_rsp_drained: got %b want 0", icb_rsp_valid); end
    endtask

    task automatic test_partial_mask();
        drive_cmd(1'b0, 16'd5, 64'hAAAAAAAABBBBBBBB, 8'h0F);
        tick();
        drive_cmd(1'b1, 16'd5, 64'h0, 8'h0);
        tick();
        set_idle();
        #1;
        vec_cnt++; if (icb_rsp_rdata !== 64'h11223344BBBBBBBB) begin err_cnt++; $display("FAIL mask_rdata: got %h want 11223344bbbbbbbb", icb_rsp_rdata); end
        tick();
    endtask

    task automatic test_backpressure();
        drive_cmd(1'b1, 16'd5, 64'h0, 8'h0);
        tick();
        icb_rsp_ready = 1'b0;
        drive_cmd(1'b0, 16'd7, 64'hDEADBEEFCAFEF00D, 8'hFF);
        for (int i = 0; i < 4; i++) begin
            #1;
            vec_cnt++; if (icb_cmd_ready !== 1'b0) begin err_cnt++; $display("FAIL bp_cmd_ready[%0d]: got %b want 0", i, icb_cmd_ready); end
            vec_cnt++; if (ram_cs !== 1'b0) begin err_cnt++; $display("FAIL bp_ram_cs[%0d]: got %b want 0", i, ram_cs); end
            vec_cnt++; if (icb_rsp_valid !== 1'b1) begin err_cnt++; $display("FAIL bp_rsp_valid[%0d]: got %b want 1", i, icb_rsp_valid); end
            vec_cnt++; if (icb_rsp_rdata !== 64'h11223344BBBBBBBB) begin err_cnt++; $display("FAIL bp_rdata[%0d]: got %h want 11223344bbbbbbbb", i, icb_rsp_rdata); end
            tick();
        end
        icb_rsp_ready = 1'b1;
        #1;
        vec_cnt++; if (icb_cmd_ready !== 1'b1 || ram_cs !== 1'b1) begin err_cnt++; $display("FAIL bp_release: got ready=%b cs=%b want 1 1", icb_cmd_ready, ram_cs); end
        tick();
        set_idle();
        #1;
        vec_cnt++; if (icb_rsp_valid !== 1'b1 || icb_rsp_rdata !== 64'h0 || icb_rsp_err !== 1'b0) begin
            err_cnt++; $display("FAIL bp_next_rsp: got v=%b d=%h e=%b want v=1 d=0 e=0", icb_rsp_valid, icb_rsp_rdata, icb_rsp_err);
        end
        tick();
    endtask

    task automatic test_oob();
        drive_cmd(1'b1, 16'(TB_DP), 64'h0, 8'h0);
        #1;
        vec_cnt++; if (icb_cmd_ready !== 1'b1 || ram_cs !== 1'b0) begin err_cnt++; $display("FAIL oob_strobe: got ready=%b cs=%b want 1 0", icb_cmd_ready, ram_cs); end
        tick();
        set_idle();
        #1;
        vec_cnt++; if (icb_rsp_valid !== 1'b1 || icb_rsp_err !== 1'b1) begin err_cnt++; $display("FAIL oob_rsp: got v=%b e=%b want 1 1", icb_rsp_valid, icb_rsp_err); end
        vec_cnt++; if (icb_rsp_rdata !== 64'h0) begin err_cnt++; $display("FAIL oob_rdata: got %h want 0", icb_rsp_rdata); end
        tick();
        // Last valid word
        drive_cmd(1'b0, 16'(TB_DP - 1), 64'h0123456789ABCDEF, 8'hFF);
        #1;
        vec_cnt++; if (ram_cs !== 1'b1) begin err_cnt++; $display("FAIL top_wr_cs: got %b want 1", ram_cs); end
        tick();
        drive_cmd(1'b0, 16'(TB_DP - 1), 64'hFFFFFFFFFFFFFFFF, 8'h00);
        #1;
        vec_cnt++; if (ram_cs !== 1'b1 || ram_wem !== 8'h00) begin err_cnt++; $display("FAIL zmask_strobe: got cs=%b wem=%h want 1 00", ram_cs, ram_wem); end
        tick();
        drive_cmd(1'b1, 16'(TB_DP - 1), 64'h0, 8'h0);
        #1;
        vec_cnt++; if (icb_rsp_valid !== 1'b1 || icb_rsp_err !== 1'b0) begin err_cnt++; $display("FAIL zmask_rsp: got v=%b e=%b want 1 0", icb_rsp_valid, icb_rsp_err); end
        tick();
        set_idle();
        #1;
        vec_cnt++; if (icb_rsp_rdata !== 64'h0123456789ABCDEF || icb_rsp_err !== 1'b0) begin
            err_cnt++; $display("FAIL top_rdata: got %h e=%b want 0123456789abcdef e=0", icb_rsp_rdata, icb_rsp_err);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            drive_cmd(1'b0, 16'(2 + i), {32'hC0DE0000 + 32'(i), 32'h12345670 + 32'(i)}, 8'hFF);
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            drive_cmd(1'b1, 16'(2 + i), 64'h0, 8'h0);
            #1;
            vec_cnt++; if (icb_cmd_ready !== 1'b1) begin err_cnt++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, icb_cmd_ready); end
            if (i > 0) begin
                vec_cnt++;
                if (icb_rsp_valid !== 1'b1 || icb_rsp_rdata !== {32'hC0DE0000 + 32'(i - 1), 32'h12345670 + 32'(i - 1)}) begin
                    err_cnt++; $display("FAIL b2b_rsp[%0d]: got v=%b d=%h want v=1 d=%h", i - 1, icb_rsp_valid, icb_rsp_rdata,
                                        {32'hC0DE0000 + 32'(i - 1), 32'h12345670 + 32'(i - 1)});
                end
            end
            tick();
        end
        set_idle();
        #1;
        vec_cnt++; if (icb_rsp_valid !== 1'b1 || icb_rsp_rdata !== 64'hC0DE000712345677) begin
            err_cnt++; $display("FAIL b2b_rsp[7]: got v=%b d=%h want v=1 d=c0de000712345677", icb_rsp_valid, icb_rsp_rdata);
        end
        tick();
        vec_cnt++; if (icb_rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL b2b_drain: got %b want 0", icb_rsp_valid); end
    endtask

    task automatic test_reset_pending();
        drive_cmd(1'b1, 16'd5, 64'h0, 8'h0);
        tick();
        icb_rsp_ready = 1'b0;
        set_idle();
        #1;
        vec_cnt++; if (icb_rsp_valid !== 1'b1) begin err_cnt++; $display("FAIL pend_valid: got %b want 1", icb_rsp_valid); end
        rst_n = 1'b0;
        #1;
        vec_cnt++; if (icb_rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL pend_dropped: got %b want 0", icb_rsp_valid); end
        tick();
        rst_n = 1'b1;
        icb_rsp_ready = 1'b1;
        #1;
        wait_ready();
        vec_cnt++; if (icb_rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL pend_after: got %b want 0", icb_rsp_valid); end
    endtask

`ifdef E203_ITCM_INIT_CLR_EN
    task automatic test_init();
        int k;
        for (int i = 0; i < TB_DP; i++) begin
            drive_cmd(1'b0, 16'(i), 64'h5A5A5A5A00000000 + 64'(i + 1), 8'hFF);
            tick();
        end
        set_idle();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        for (k = 0; k < 8; k++) begin
            vec_cnt++;
            if (ram_cs !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 16'(k) || ram_wem !== 8'hFF || ram_din !== 64'h0 || icb_cmd_ready !== 1'b0) begin
                err_cnt++; $display("FAIL init1_sweep[%0d]: got cs=%b we=%b a=%0d wem=%h din=%h rdy=%b", k, ram_cs, ram_we, ram_addr, ram_wem, ram_din, icb_cmd_ready);
            end
            tick();
        end
        rst_n = 1'b0;
        #1;
        vec_cnt++; if (ram_cs !== 1'b0 || init_done !== 1'b0) begin err_cnt++; $display("FAIL init_mid_reset: got cs=%b done=%b want 0 0", ram_cs, init_done); end
        tick();
        rst_n = 1'b1;
        #1;
        k = 0;
        while (!init_done && k < 64) begin
            vec_cnt++;
            if (ram_cs !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 16'(k) || icb_cmd_ready !== 1'b0) begin
                err_cnt++; $display("FAIL init2_sweep[%0d]: got cs=%b we=%b a=%0d rdy=%b", k, ram_cs, ram_we, ram_addr, icb_cmd_ready);
            end
            tick();
            k++;
        end
        vec_cnt++; if (k != TB_DP) begin err_cnt++; $display("FAIL init_cycles: got %0d want %0d", k, TB_DP); end
        for (int i = 0; i < TB_DP; i++) begin
            drive_cmd(1'b1, 16'(i), 64'h0, 8'h0);
            tick();
            set_idle();
            #1;
            vec_cnt++; if (icb_rsp_valid !== 1'b1 || icb_rsp_rdata !== 64'h0) begin
                err_cnt++; $display("FAIL init_clear[%0d]: got v=%b d=%h want v=1 d=0", i, icb_rsp_valid, icb_rsp_rdata);
            end
            tick();
        end
    endtask
`endif

    initial begin
        set_idle();
        rst_n = 1'b0;
        icb_rsp_ready = 1'b1;
        test_reset();
        test_write_read();
        test_partial_mask();
        test_backpressure();
        test_oob();
        test_back_to_back();
        test_reset_pending();
`ifdef E203_ITCM_INIT_CLR_EN
        test_init();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
